// File: rtl/alu_pipe_pkg.sv
// ---------------------------------------------------------------------------
// alu_pipe_pkg
// Shared definitions for the pipelined ALU: opcode width, opcode encodings
// and small helpers that classify an opcode. Carry handling and overflow
// gating in alu_core and alu_pipe are built on these helpers.
// ---------------------------------------------------------------------------
package alu_pipe_pkg;

  localparam int OP_W = 4;

  typedef logic [OP_W-1:0] op_t;

  localparam op_t OP_ADD   = 4'd0;
  localparam op_t OP_SUB   = 4'd1;
  localparam op_t OP_AND   = 4'd2;
  localparam op_t OP_OR    = 4'd3;
  localparam op_t OP_XOR   = 4'd4;
  localparam op_t OP_NOTA  = 4'd5;
  localparam op_t OP_SHL   = 4'd6;
  localparam op_t OP_SHR   = 4'd7;
  localparam op_t OP_SRA   = 4'd8;
  localparam op_t OP_ADC   = 4'd9;
  localparam op_t OP_SBC   = 4'd10;
  localparam op_t OP_PASSB = 4'd11;

  // Add/subtract family: the only ops that produce a signed overflow flag.
  function automatic logic is_arith(op_t op);
    return op inside {OP_ADD, OP_SUB, OP_ADC, OP_SBC};
  endfunction

  // Shift family: carry is the last bit shifted out.
  function automatic logic is_shift(op_t op);
    return op inside {OP_SHL, OP_SHR, OP_SRA};
  endfunction

  // Ops whose carry result is remembered for a following ADC/SBC.
  // Logic ops, PASS B and illegal codes leave the stored carry alone.
  function automatic logic updates_carry(op_t op);
    return is_arith(op) | is_shift(op);
  endfunction

  // Codes 12..15 are unassigned and flagged as errors.
  function automatic logic is_legal(op_t op);
    return op <= OP_PASSB;
  endfunction

endpackage

// File: rtl/alu_core.sv
// ---------------------------------------------------------------------------
// alu_core
// Purely combinational ALU datapath. No state; the carry-in for ADC/SBC is
// supplied by the enclosing pipeline.
// Ports:
//   a, b    in   WIDTH  operands (shift amount = low $clog2(WIDTH) bits of b)
//   op      in   OP_W   opcode (see alu_pipe_pkg)
//   cin     in   1      stored carry/borrow, used by ADC and SBC only
//   result  out  WIDTH  result, truncated to WIDTH
//   carry   out  1      carry / borrow / last shifted-out bit
//   zero    out  1      result == 0
//   neg     out  1      result MSB
//   ovf     out  1      signed overflow, add/subtract family only
//   err     out  1      illegal opcode
// ---------------------------------------------------------------------------
module alu_core
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  input  logic             cin,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             neg,
  output logic             ovf,
  output logic             err
);

  localparam int SW = $clog2(WIDTH);

  logic [SW-1:0]       shamt;
  logic                add_cin;
  logic                sub_cin;
  logic [WIDTH:0]      sum_ext;
  logic [WIDTH:0]      diff_ext;
  logic [WIDTH:0]      shl_ext;
  logic [WIDTH:0]      shr_ext;
  logic signed [WIDTH:0] sra_ext;

  // One-bit-wider intermediates for every op. Arithmetic keeps the carry or
  // borrow in bit WIDTH. For shifts the extra bit catches the last bit
  // shifted out: above the MSB for left shifts, below the LSB for right
  // shifts. A zero shift amount therefore naturally gives a carry of 0.
  always_comb begin
    shamt    = b[SW-1:0];
    add_cin  = (op == OP_ADC) ? cin : 1'b0;
    sub_cin  = (op == OP_SBC) ? cin : 1'b0;
    sum_ext  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, add_cin};
    diff_ext = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, sub_cin};
    shl_ext  = {1'b0, a} << shamt;
    shr_ext  = {a, 1'b0} >> shamt;
    sra_ext  = $signed({a, 1'b0}) >>> shamt;
  end

  // Opcode decode. Signed overflow is the sign-extended result's bit WIDTH
  // disagreeing with bit WIDTH-1. The sign-extended bit WIDTH equals the
  // unsigned bit WIDTH XOR both operand MSBs, so no second adder is needed.
  always_comb begin
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    err    = 1'b0;
    case (op)
      OP_ADD, OP_ADC: begin
        result = sum_ext[WIDTH-1:0];
        carry  = sum_ext[WIDTH];
        ovf    = sum_ext[WIDTH] ^ sum_ext[WIDTH-1] ^ a[WIDTH-1] ^ b[WIDTH-1];
      end
      OP_SUB, OP_SBC: begin
        result = diff_ext[WIDTH-1:0];
        carry  = diff_ext[WIDTH];
        ovf    = diff_ext[WIDTH] ^ diff_ext[WIDTH-1] ^ a[WIDTH-1] ^ b[WIDTH-1];
      end
      OP_AND:   result = a & b;
      OP_OR:    result = a | b;
      OP_XOR:   result = a ^ b;
      OP_NOTA:  result = ~a;
      OP_SHL: begin
        result = shl_ext[WIDTH-1:0];
        carry  = shl_ext[WIDTH];
      end
      OP_SHR: begin
        result = shr_ext[WIDTH:1];
        carry  = shr_ext[0];
      end
      OP_SRA: begin
        result = sra_ext[WIDTH:1];
        carry  = sra_ext[0];
      end
      OP_PASSB: result = b;
      default:  err    = ~is_legal(op);
    endcase
  end

  // Status flags follow the final result, so an illegal op reports zero.
  always_comb begin
    zero = (result == '0);
    neg  = result[WIDTH-1];
  end

endmodule

// File: rtl/alu_pipe.sv
// ---------------------------------------------------------------------------
// alu_pipe
// Two-stage pipelined ALU with valid/ready handshakes on both sides.
// S1 registers the operand beat. S2 registers the alu_core result and flags,
// and S2 drives the out_* ports directly. A carry register chains ADC/SBC
// across beats.
// Ports:
//   clk, rst     clock (rising edge), asynchronous active-high reset
//   flush        synchronous clear of both stages and the carry register
//   in_valid/in_ready, in_a, in_b, in_op     operand handshake
//   out_valid/out_ready, out_result, out_carry, out_zero, out_neg,
//   out_ovf, out_err                          result handshake
// ---------------------------------------------------------------------------
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [OP_W-1:0]  in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_ovf,
  output logic             out_err
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [OP_W-1:0]  s1_op;
  logic             carry_q;

  logic             s2_load;
  logic             accept;

  logic [WIDTH-1:0] core_result;
  logic             core_carry;
  logic             core_zero;
  logic             core_neg;
  logic             core_ovf;
  logic             core_err;

  // Handshake. S2 can take S1's beat when it is empty or is being drained
  // this cycle. in_ready depends combinationally on out_ready so a full
  // pipe still sustains one beat per cycle. Flush blocks new beats so that
  // nothing is accepted into a pipe that is being cleared.
  always_comb begin
    s2_load  = s1_valid & (~out_valid | out_ready);
    in_ready = ~flush & (~s1_valid | s2_load);
    accept   = in_valid & in_ready;
  end

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a      (s1_a),
    .b      (s1_b),
    .op     (s1_op),
    .cin    (carry_q),
    .result (core_result),
    .carry  (core_carry),
    .zero   (core_zero),
    .neg    (core_neg),
    .ovf    (core_ovf),
    .err    (core_err)
  );

  // Stage 1 operand register. A new beat may enter in the same cycle the
  // previous one moves to S2. Otherwise S1 empties when its beat leaves.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_op    <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_a     <= in_a;
      s1_b     <= in_b;
      s1_op    <= in_op;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // Carry register for multi-word chains. It is written when a beat moves
  // from S1 to S2, so an ADC sitting in S1 right behind an ADD already sees
  // that ADD's carry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_q <= 1'b0;
    end else if (flush) begin
      carry_q <= 1'b0;
    end else if (s2_load && updates_carry(s1_op)) begin
      carry_q <= core_carry;
    end
  end

  // Stage 2 result register. These registers drive the output ports
  // directly. They only change on a load, and a load needs the sink to have
  // taken the held beat, so the outputs stay stable under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_carry  <= 1'b0;
      out_zero   <= 1'b0;
      out_neg    <= 1'b0;
      out_ovf    <= 1'b0;
      out_err    <= 1'b0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_carry  <= 1'b0;
      out_zero   <= 1'b0;
      out_neg    <= 1'b0;
      out_ovf    <= 1'b0;
      out_err    <= 1'b0;
    end else if (s2_load) begin
      out_valid  <= 1'b1;
      out_result <= core_result;
      out_carry  <= core_carry;
      out_zero   <= core_zero;
      out_neg    <= core_neg;
      out_ovf    <= core_ovf;
      out_err    <= core_err;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// ---------------------------------------------------------------------------
// tb_alu_pipe
// Scoreboard bench for alu_pipe (WIDTH=8). Each accepted beat pushes the
// reference model's expected response into a queue. A monitor pops one
// entry for each output handshake and compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_alu_pipe;
  import alu_pipe_pkg::*;

  localparam int WIDTH = 8;
  localparam int MASK  = (1 << WIDTH) - 1;
  localparam int HALF  = 1 << (WIDTH - 1);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
    logic             neg;
    logic             ovf;
    logic             err;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [OP_W-1:0]  in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_carry;
  logic             out_zero;
  logic             out_neg;
  logic             out_ovf;
  logic             out_err;

  logic [WIDTH+5:0] out_bus;
  assign out_bus = {out_valid, out_result, out_carry, out_zero, out_neg, out_ovf, out_err};

  exp_t sb[$];
  int   model_carry;
  int   total;
  int   bad;
  int   beats_seen;
  bit   rand_done;

  alu_pipe #(
    .WIDTH (WIDTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_carry  (out_carry),
    .out_zero   (out_zero),
    .out_neg    (out_neg),
    .out_ovf    (out_ovf),
    .out_err    (out_err)
  );

  // Free-running 10-time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard against a hung run.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Counts every comparison and reports each mismatch on one line.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int toSigned(input int v);
    return (v >= HALF) ? v - (1 << WIDTH) : v;
  endfunction

  // Reference model in plain integer arithmetic: results are exact integers,
  // and carry, borrow and overflow fall out of range tests on them.
  function automatic exp_t refModel(input int a, input int b, input int op, input int cin);
    exp_t e;
    int r, c, v, sa, sbv, sv, n;
    r = 0; c = 0; v = 0; sv = 0;
    sa = toSigned(a);
    sbv = toSigned(b);
    n = b % WIDTH;
    e.err = 1'b0;
    case (op)
      0, 9: begin
        r = a + b + ((op == 9) ? cin : 0);
        c = (r > MASK) ? 1 : 0;
        sv = sa + sbv + ((op == 9) ? cin : 0);
        v = (sv >= HALF || sv < -HALF) ? 1 : 0;
      end
      1, 10: begin
        r = a - b - ((op == 10) ? cin : 0);
        c = (r < 0) ? 1 : 0;
        sv = sa - sbv - ((op == 10) ? cin : 0);
        v = (sv >= HALF || sv < -HALF) ? 1 : 0;
      end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = ~a;
      6: begin
        r = a << n;
        c = (n == 0) ? 0 : ((a >> (WIDTH - n)) & 1);
      end
      7: begin
        r = a >> n;
        c = (n == 0) ? 0 : ((a >> (n - 1)) & 1);
      end
      8: begin
        r = sa >>> n;
        c = (n == 0) ? 0 : ((sa >>> (n - 1)) & 1);
      end
      11: r = b;
      default: e.err = 1'b1;
    endcase
    e.result = WIDTH'(r & MASK);
    e.carry  = c[0];
    e.zero   = (e.result == '0);
    e.neg    = e.result[WIDTH-1];
    e.ovf    = v[0];
    return e;
  endfunction

  // Presents one beat and holds it until accepted. The expected response is
  // queued at the accepting edge, and the model carry advances in issue
  // order. Called and returns at posedge+1.
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic [OP_W-1:0] op);
    bit   done;
    int   k;
    exp_t e;
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
    done = 0; k = 0;
    while (!done && k < 200) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        e = refModel(int'(a), int'(b), int'(op), model_carry);
        sb.push_back(e);
        if (int'(op) inside {0, 1, 6, 7, 8, 9, 10}) model_carry = int'(e.carry);
        done = 1;
      end
      @(posedge clk); #1;
      k++;
    end
    if (!done) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
    end
  endtask

  task automatic idleCycles(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drainAll();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 500) begin
      @(posedge clk); #1;
      k++;
    end
    checkOutput("drain_empty", sb.size(), 32'd0);
  endtask

  // Monitor: every output handshake consumes the oldest expected response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_beat", {18'd0, out_bus}, 32'd0);
        end else begin
          e = sb.pop_front();
          checkOutput($sformatf("beat%0d", beats_seen),
                      {out_result, out_carry, out_zero, out_neg, out_ovf, out_err}, e);
        end
        beats_seen++;
      end
    end
  end

  // Main stimulus sequence.
  initial begin
    logic [WIDTH+5:0] snap;
    int base;
    total = 0; bad = 0; beats_seen = 0; model_carry = 0; rand_done = 0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_op = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_outs", {18'd0, out_bus}, 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("reset_in_ready", in_ready, 32'd1);
    @(posedge clk); #1;

    // Carry chain, latency and directed flag cases.
    $display("[TB] directed ops");
    out_ready = 1'b1;
    applyStimulus(8'hFF, 8'h01, OP_ADD);
    fork
      begin
        @(negedge clk);
        checkOutput("latency_s1_only", out_valid, 32'd0);
        @(negedge clk);
        checkOutput("latency_out_valid", out_valid, 32'd1);
      end
    join_none
    applyStimulus(8'h00, 8'h00, OP_ADC);
    applyStimulus(8'h7F, 8'h01, OP_ADD);
    applyStimulus(8'h05, 8'h07, OP_SUB);
    applyStimulus(8'h80, 8'h03, OP_SRA);
    applyStimulus(8'h81, 8'h01, OP_SHL);
    applyStimulus(8'h5A, 8'hA5, 4'hC);
    applyStimulus(8'h80, 8'h00, OP_SBC);
    idleCycles(1);
    drainAll();

    // Backpressure: two beats fill the pipe, the rest wait for the sink.
    $display("[TB] backpressure");
    out_ready = 1'b0;
    applyStimulus(8'h10, 8'h20, OP_ADD);
    applyStimulus(8'h3C, 8'h0F, OP_XOR);
    fork
      begin
        applyStimulus(8'h01, 8'h01, OP_ADC);
        applyStimulus(8'hF0, 8'h04, OP_SHR);
        in_valid = 1'b0;
      end
      begin
        @(negedge clk);
        checkOutput("bp_in_ready_low", in_ready, 32'd0);
        snap = out_bus;
        repeat (3) begin
          @(negedge clk);
          checkOutput("bp_outputs_held", {18'd0, out_bus}, {18'd0, snap});
          checkOutput("bp_still_full", in_ready, 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        base = beats_seen;
        repeat (4) @(negedge clk);
        #1;
        checkOutput("bp_release_rate", beats_seen - base, 32'd4);
      end
    join
    drainAll();

    // Flush with two beats in flight; the carry from the flushed ADD must not survive.
    $display("[TB] flush");
    @(posedge clk); #1;
    out_ready = 1'b0;
    applyStimulus(8'hFF, 8'h01, OP_ADD);
    applyStimulus(8'h03, 8'h04, OP_SUB);
    in_a = 8'h11; in_b = 8'h22; in_op = OP_OR; in_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    checkOutput("flush_in_ready_low", in_ready, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    model_carry = 0;
    checkOutput("flush_out_valid", out_valid, 32'd0);
    out_ready = 1'b1;
    base = beats_seen;
    idleCycles(3);
    checkOutput("flush_no_beats", beats_seen - base, 32'd0);
    applyStimulus(8'h00, 8'h00, OP_ADC);
    idleCycles(1);
    drainAll();

    // Asynchronous reset between clock edges.
    $display("[TB] async reset");
    out_ready = 1'b0;
    applyStimulus(8'hFF, 8'h02, OP_ADD);
    applyStimulus(8'h0F, 8'hF0, OP_OR);
    in_valid = 1'b0;
    checkOutput("pre_rst_valid", out_valid, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_async_outs", {18'd0, out_bus}, 32'd0);
    sb.delete();
    model_carry = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checkOutput("rst_in_ready", in_ready, 32'd1);
    out_ready = 1'b1;
    applyStimulus(8'h00, 8'h00, OP_ADC);
    idleCycles(1);
    drainAll();

    // Random traffic with random sink stalls.
    $display("[TB] random traffic");
    fork
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    for (int i = 0; i < 300; i++) begin
      applyStimulus(WIDTH'($urandom), WIDTH'($urandom), OP_W'($urandom_range(0, 15)));
      if ($urandom_range(0, 4) == 0) idleCycles($urandom_range(1, 3));
    end
    in_valid = 1'b0;
    rand_done = 1;
    repeat (2) @(posedge clk);
    #2;
    out_ready = 1'b1;
    drainAll();
    checkOutput("beats_total_seen", (beats_seen > 300) ? 32'd1 : 32'd0, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
